// File: rtl/nanorv32_csr_access.sv
`default_nettype none
// ============================================================================
// Module   : nanorv32_csr_access
// Purpose  : Runs one Zicsr instruction (CSRRW/RS/RC and immediate forms)
//            as a read-modify-write sequence on the core_csr_* bus, then
//            returns the old CSR value to the register file.
// Revision : 1.0 - initial release
// ============================================================================
module nanorv32_csr_access #(
  parameter int CSR_ADDR_W = 12,
  parameter int DATA_W     = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [2:0]            req_funct3,
  input  logic [CSR_ADDR_W-1:0] req_addr,
  input  logic [4:0]            req_rs1_idx,
  input  logic [DATA_W-1:0]     req_rs1_val,
  input  logic [4:0]            req_rd_idx,
  input  logic                  stall_exe,
  input  logic                  flush,
  output logic [CSR_ADDR_W-1:0] core_csr_addr,
  output logic [DATA_W-1:0]     core_csr_wdata,
  output logic                  core_csr_write,
  input  logic [DATA_W-1:0]     csr_core_rdata,
  output logic                  rf_we,
  output logic [4:0]            rf_waddr,
  output logic [DATA_W-1:0]     rf_wdata,
  output logic                  illegal,
  output logic                  done
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_WR   = 3'd2,
    S_WB   = 3'd3,
    S_BAD  = 3'd4
  } state_t;

  state_t state;
  state_t state_nxt;

  // Operation latches: low two funct3 bits select RW/RS/RC, bit 2 only
  // affects operand selection and is folded into operand_r at accept time.
  logic [1:0]            kind_r;
  logic [CSR_ADDR_W-1:0] addr_r;
  logic [4:0]            rd_r;
  logic [DATA_W-1:0]     operand_r;
  logic                  rs1_zero_r;
  logic [DATA_W-1:0]     old_r;
  logic                  illegal_r;

  logic                  accept;
  logic                  funct3_ok;
  logic                  wr_req;
  logic                  ro;
  logic [DATA_W-1:0]     new_val;
  logic [DATA_W-1:0]     operand_in;

  assign accept     = req_valid & (state == S_IDLE) & ~stall_exe;
  assign funct3_ok  = (req_funct3[1:0] != 2'b00);
  assign operand_in = req_funct3[2] ? {{(DATA_W-5){1'b0}}, req_rs1_idx} : req_rs1_val;
  // RW always writes; RS/RC with x0 or zimm=0 are pure reads.
  assign wr_req     = (kind_r == 2'b01) | ~rs1_zero_r;
  // Top two address bits 11 mark the read-only CSR space.
  assign ro         = (addr_r[CSR_ADDR_W-1 -: 2] == 2'b11);
  assign rf_waddr   = rd_r;

  // Modified value: bitwise set/clear against the sampled old value.
  always_comb begin
    new_val = operand_r;
    case (kind_r)
      2'b10:   new_val = old_r | operand_r;
      2'b11:   new_val = old_r & ~operand_r;
      default: new_val = operand_r;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and bus/writeback outputs; stall holds the state and masks strobes, flush wins over stall.
  always_comb begin
    state_nxt      = state;
    req_ready      = 1'b0;
    core_csr_addr  = '0;
    core_csr_wdata = '0;
    core_csr_write = 1'b0;
    rf_we          = 1'b0;
    rf_wdata       = '0;
    illegal        = 1'b0;
    done           = 1'b0;
    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (accept) begin
          state_nxt = funct3_ok ? S_RD : S_BAD;
        end
      end
      S_RD: begin
        core_csr_addr = addr_r;
        if (flush) begin
          state_nxt = S_IDLE;
        end else if (!stall_exe) begin
          state_nxt = S_WR;
        end
      end
      S_WR: begin
        core_csr_addr = addr_r;
        if (flush) begin
          state_nxt = S_IDLE;
        end else if (!stall_exe) begin
          if (wr_req && ro) begin
            illegal = 1'b1;
          end else if (wr_req) begin
            core_csr_write = 1'b1;
            core_csr_wdata = new_val;
          end
          state_nxt = S_WB;
        end
      end
      S_WB: begin
        rf_wdata = old_r;
        if (!stall_exe) begin
          rf_we     = (rd_r != 5'd0) & ~illegal_r;
          done      = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      S_BAD: begin
        illegal   = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Operation latches: captured on accept, old value re-sampled every RD cycle, illegal flag set in WR.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      kind_r     <= '0;
      addr_r     <= '0;
      rd_r       <= '0;
      operand_r  <= '0;
      rs1_zero_r <= 1'b0;
      old_r      <= '0;
      illegal_r  <= 1'b0;
    end else begin
      if (accept) begin
        kind_r     <= req_funct3[1:0];
        addr_r     <= req_addr;
        rd_r       <= req_rd_idx;
        operand_r  <= operand_in;
        rs1_zero_r <= (req_rs1_idx == 5'd0);
        illegal_r  <= 1'b0;
      end
      if (state == S_RD) begin
        old_r <= csr_core_rdata;
      end
      if ((state == S_WR) && illegal) begin
        illegal_r <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_nanorv32_csr_access.sv
`default_nettype none
// ============================================================================
// Module   : tb_nanorv32_csr_access
// Purpose  : Self-checking bench: directed vector table, corner sequences
//            and randomized traffic against a behavioural reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nanorv32_csr_access;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_funct3;
  logic [11:0] req_addr;
  logic [4:0]  req_rs1_idx;
  logic [31:0] req_rs1_val;
  logic [4:0]  req_rd_idx;
  logic        stall_exe;
  logic        flush;
  logic [11:0] core_csr_addr;
  logic [31:0] core_csr_wdata;
  logic        core_csr_write;
  logic [31:0] csr_core_rdata;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        illegal;
  logic        done;

  int errors = 0;
  int checks = 0;

  // CSR block model: combinational read, write on clock edge, plus bench pokes.
  logic [31:0] mem [0:4095];
  logic        mem_clr;
  logic        poke_en;
  logic [11:0] poke_addr;
  logic [31:0] poke_data;

  assign csr_core_rdata = mem[core_csr_addr];

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 4096; i++) mem[i] <= 32'd0;
    end else if (core_csr_write) begin
      mem[core_csr_addr] <= core_csr_wdata;
    end else if (poke_en) begin
      mem[poke_addr] <= poke_data;
    end
  end

  always #5 clk = ~clk;

  nanorv32_csr_access #(.CSR_ADDR_W(12), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_rs1_idx(req_rs1_idx), .req_rs1_val(req_rs1_val),
    .req_rd_idx(req_rd_idx), .stall_exe(stall_exe), .flush(flush),
    .core_csr_addr(core_csr_addr), .core_csr_wdata(core_csr_wdata),
    .core_csr_write(core_csr_write), .csr_core_rdata(csr_core_rdata),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .illegal(illegal), .done(done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic poke(input logic [11:0] a, input logic [31:0] d);
    poke_en = 1'b1; poke_addr = a; poke_data = d;
    @(negedge clk);
    poke_en = 1'b0;
  endtask

  task automatic drive_req(input logic [2:0] f3, input logic [11:0] a, input logic [4:0] rs1,
                           input logic [31:0] rs1v, input logic [4:0] rd);
    req_valid = 1'b1; req_funct3 = f3; req_addr = a;
    req_rs1_idx = rs1; req_rs1_val = rs1v; req_rd_idx = rd;
  endtask

  typedef struct {
    logic [2:0]  f3;
    logic [11:0] addr;
    logic [4:0]  rs1;
    logic [31:0] rs1v;
    logic [4:0]  rd;
    logic [31:0] init;
    logic        exp_wr;
    logic [31:0] exp_wdata;
    logic        exp_ill;
    logic        exp_rfwe;
    logic [31:0] exp_rfd;
  } vec_t;

  vec_t vecs [9];

  // Reference-model bookkeeping for the random phase.
  bit          m_busy, m_bad;
  int          m_step;
  logic [11:0] m_addr;
  logic [4:0]  m_rd;
  logic [31:0] m_old, m_new;
  bit          m_wreq, m_ro, m_ill;
  logic [11:0] addr_pool [6];

  initial begin
    rst = 1'b1; mem_clr = 1'b1; poke_en = 1'b0; poke_addr = '0; poke_data = '0;
    req_valid = 1'b0; req_funct3 = '0; req_addr = '0; req_rs1_idx = '0;
    req_rs1_val = '0; req_rd_idx = '0; stall_exe = 1'b0; flush = 1'b0;

    //          f3    addr    rs1   rs1v          rd    init          wr wdata        ill rfwe rfd
    vecs[0] = '{3'b001, 12'h340, 5'd6, 32'hDEADBEEF, 5'd5,  32'h00000012, 1, 32'hDEADBEEF, 0, 1, 32'h00000012};
    vecs[1] = '{3'b010, 12'h300, 5'd8, 32'h0000000F, 5'd7,  32'h000000F0, 1, 32'h000000FF, 0, 1, 32'h000000F0};
    vecs[2] = '{3'b011, 12'h300, 5'd8, 32'h0000000F, 5'd7,  32'h000000F0, 1, 32'h000000F0, 0, 1, 32'h000000F0};
    vecs[3] = '{3'b010, 12'hC00, 5'd0, 32'h00000000, 5'd3,  32'h00001234, 0, 32'h00000000, 0, 1, 32'h00001234};
    vecs[4] = '{3'b101, 12'hC01, 5'd5, 32'h00000000, 5'd0,  32'h00000077, 0, 32'h00000000, 1, 0, 32'h00000000};
    vecs[5] = '{3'b110, 12'h305, 5'd31, 32'hFFFFFFFF, 5'd9, 32'h00000100, 1, 32'h0000011F, 0, 1, 32'h00000100};
    vecs[6] = '{3'b111, 12'h305, 5'd3, 32'hFFFFFFFF, 5'd10, 32'h0000000F, 1, 32'h0000000C, 0, 1, 32'h0000000F};
    vecs[7] = '{3'b001, 12'hC00, 5'd2, 32'h00005555, 5'd4,  32'h00000099, 0, 32'h00000000, 1, 0, 32'h00000000};
    vecs[8] = '{3'b011, 12'h7C0, 5'd0, 32'hFFFFFFFF, 5'd6,  32'h000000AB, 0, 32'h00000000, 0, 1, 32'h000000AB};

    repeat (3) @(negedge clk);
    #1;
    check("reset_ready", req_ready, 1);
    check("reset_write", core_csr_write, 0);
    check("reset_rfwe", rf_we, 0);
    check("reset_done", done, 0);
    check("reset_illegal", illegal, 0);
    check("reset_addr", core_csr_addr, 0);
    check("reset_waddr", rf_waddr, 0);
    rst = 1'b0; mem_clr = 1'b0;
    @(negedge clk);

    // Directed vectors, fixed latency N+1 RD, N+2 WR, N+3 WB, N+4 idle.
    for (int i = 0; i < 9; i++) begin
      poke(vecs[i].addr, vecs[i].init);
      drive_req(vecs[i].f3, vecs[i].addr, vecs[i].rs1, vecs[i].rs1v, vecs[i].rd);
      #1 check($sformatf("v%0d_ready", i), req_ready, 1);
      @(negedge clk); req_valid = 1'b0;
      #1 check($sformatf("v%0d_rd_addr", i), core_csr_addr, vecs[i].addr);
      check($sformatf("v%0d_rd_write", i), core_csr_write, 0);
      @(negedge clk); #1;
      check($sformatf("v%0d_write", i), core_csr_write, vecs[i].exp_wr);
      check($sformatf("v%0d_wdata", i), core_csr_wdata, vecs[i].exp_wr ? vecs[i].exp_wdata : 32'd0);
      check($sformatf("v%0d_illegal", i), illegal, vecs[i].exp_ill);
      @(negedge clk); #1;
      check($sformatf("v%0d_rfwe", i), rf_we, vecs[i].exp_rfwe);
      if (vecs[i].exp_rfwe) begin
        check($sformatf("v%0d_rfdata", i), rf_wdata, vecs[i].exp_rfd);
        check($sformatf("v%0d_rfaddr", i), rf_waddr, vecs[i].rd);
      end
      check($sformatf("v%0d_done", i), done, 1);
      check($sformatf("v%0d_wb_illegal", i), illegal, 0);
      @(negedge clk); #1;
      check($sformatf("v%0d_ready_back", i), req_ready, 1);
      check($sformatf("v%0d_done_off", i), done, 0);
      check($sformatf("v%0d_mem", i), mem[vecs[i].addr], vecs[i].exp_wr ? vecs[i].exp_wdata : vecs[i].init);
    end

    // Unsupported funct3: illegal pulse next cycle, no bus activity.
    drive_req(3'b100, 12'h340, 5'd1, 32'h1, 5'd1);
    @(negedge clk); req_valid = 1'b0;
    #1 check("bad_illegal", illegal, 1);
    check("bad_write", core_csr_write, 0);
    check("bad_rfwe", rf_we, 0);
    check("bad_ready", req_ready, 0);
    @(negedge clk); #1;
    check("bad_ready_back", req_ready, 1);
    check("bad_illegal_off", illegal, 0);

    // Stall 3 cycles in WR: one strobe after release, done delayed by 3.
    poke(12'h341, 32'h00000021);
    drive_req(3'b001, 12'h341, 5'd6, 32'hCAFEF00D, 5'd8);
    @(negedge clk); req_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); stall_exe = 1'b1;
      #1 check($sformatf("stallwr%0d_write", k), core_csr_write, 0);
      check($sformatf("stallwr%0d_done", k), done, 0);
    end
    @(negedge clk); stall_exe = 1'b0;
    #1 check("stallwr_write", core_csr_write, 1);
    check("stallwr_wdata", core_csr_wdata, 32'hCAFEF00D);
    @(negedge clk); #1;
    check("stallwr_post_write", core_csr_write, 0);
    check("stallwr_done", done, 1);
    check("stallwr_rfdata", rf_wdata, 32'h00000021);
    @(negedge clk); #1 check("stallwr_ready", req_ready, 1);

    // Stall in RD while the CSR changes: the last sampled value wins.
    poke(12'h342, 32'h0000AAAA);
    drive_req(3'b010, 12'h342, 5'd4, 32'h00000001, 5'd9);
    @(negedge clk); req_valid = 1'b0; stall_exe = 1'b1;
    #1 check("stallrd_addr", core_csr_addr, 12'h342);
    poke(12'h342, 32'h0000BBBB);
    stall_exe = 1'b0;
    @(negedge clk); #1;
    check("stallrd_wdata", core_csr_wdata, 32'h0000BBBB);
    @(negedge clk); #1 check("stallrd_rfdata", rf_wdata, 32'h0000BBBB);

    // Flush in RD: no write, no writeback, ready next cycle.
    @(negedge clk);
    drive_req(3'b001, 12'h343, 5'd6, 32'h12345678, 5'd5);
    @(negedge clk); req_valid = 1'b0; flush = 1'b1; stall_exe = 1'b1;
    #1 check("flushrd_write", core_csr_write, 0);
    @(negedge clk); flush = 1'b0; stall_exe = 1'b0;
    #1 check("flushrd_ready", req_ready, 1);
    check("flushrd_done", done, 0);
    check("flushrd_mem", mem[12'h343], 0);

    // Flush in WR: strobe suppressed.
    drive_req(3'b001, 12'h343, 5'd6, 32'h12345678, 5'd5);
    @(negedge clk); req_valid = 1'b0;
    @(negedge clk); flush = 1'b1;
    #1 check("flushwr_write", core_csr_write, 0);
    @(negedge clk); flush = 1'b0;
    #1 check("flushwr_ready", req_ready, 1);
    check("flushwr_rfwe", rf_we, 0);
    check("flushwr_mem", mem[12'h343], 0);

    // Asynchronous reset mid-WR.
    drive_req(3'b001, 12'h343, 5'd6, 32'h87654321, 5'd5);
    @(negedge clk); req_valid = 1'b0;
    @(negedge clk); rst = 1'b1;
    #1 check("rst_write", core_csr_write, 0);
    check("rst_addr", core_csr_addr, 0);
    check("rst_ready", req_ready, 1);
    check("rst_waddr", rf_waddr, 0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk); #1;
    check("rst_done", done, 0);
    check("rst_rfwe", rf_we, 0);
    check("rst_mem", mem[12'h343], 0);

    // Randomized traffic against the reference model.
    addr_pool[0] = 12'h340; addr_pool[1] = 12'h300; addr_pool[2] = 12'hC00;
    addr_pool[3] = 12'hC01; addr_pool[4] = 12'h7C0; addr_pool[5] = 12'hF11;
    for (int i = 0; i < 6; i++) poke(addr_pool[i], $urandom);
    m_busy = 0; m_bad = 0; m_step = 0;
    m_addr = '0; m_rd = '0; m_old = '0; m_new = '0; m_wreq = 0; m_ro = 0; m_ill = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      logic [2:0]  f3;
      logic [31:0] opnd, e_wd, e_rfd;
      logic [11:0] e_addr;
      bit e_ready, e_wr, e_ill, e_rfwe, e_done;
      @(negedge clk);
      f3 = 3'($urandom);
      drive_req(f3, addr_pool[$urandom_range(0, 5)],
                ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom),
                $urandom, 5'($urandom));
      req_valid = 1'($urandom);
      stall_exe = m_busy ? ($urandom_range(0, 4) == 0) : 1'b0;
      flush     = ($urandom_range(0, 9) == 0);
      #1;
      e_ready = !m_busy; e_addr = '0; e_wr = 0; e_wd = '0; e_ill = 0;
      e_rfwe = 0; e_rfd = '0; e_done = 0;
      if (!m_busy) begin
        if (req_valid) begin
          m_busy = 1; m_step = 0;
          m_bad  = (req_funct3[1:0] == 2'b00);
          m_addr = req_addr; m_rd = req_rd_idx;
          m_old  = mem[req_addr];
          opnd   = req_funct3[2] ? {27'd0, req_rs1_idx} : req_rs1_val;
          m_new  = (req_funct3[1:0] == 2'b01) ? opnd :
                   (req_funct3[1:0] == 2'b10) ? (m_old | opnd) : (m_old & ~opnd);
          m_wreq = (req_funct3[1:0] == 2'b01) || (req_rs1_idx != 0);
          m_ro   = (req_addr[11:10] == 2'b11);
          m_ill  = m_wreq && m_ro;
        end
      end else if (m_bad) begin
        e_ill = 1; m_busy = 0;
      end else if (m_step == 0) begin
        e_addr = m_addr;
        if (flush) m_busy = 0; else if (!stall_exe) m_step = 1;
      end else if (m_step == 1) begin
        e_addr = m_addr;
        if (flush) m_busy = 0;
        else if (!stall_exe) begin
          e_wr = m_wreq && !m_ro; e_wd = e_wr ? m_new : '0; e_ill = m_ill; m_step = 2;
        end
      end else if (!stall_exe) begin
        e_rfwe = (m_rd != 0) && !m_ill; e_rfd = m_old; e_done = 1; m_busy = 0;
      end
      check("rnd_ready", req_ready, e_ready);
      check("rnd_addr", core_csr_addr, e_addr);
      check("rnd_write", core_csr_write, e_wr);
      check("rnd_wdata", core_csr_wdata, e_wd);
      check("rnd_illegal", illegal, e_ill);
      check("rnd_rfwe", rf_we, e_rfwe);
      check("rnd_done", done, e_done);
      if (e_rfwe) begin
        check("rnd_rfdata", rf_wdata, e_rfd);
        check("rnd_rfaddr", rf_waddr, m_rd);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
